// File: rtl/sobel_pkg.sv
// Shared types and window index constants for the Sobel pipeline.
// Window element k = r*3 + c, r = 0 top line, c = 0 left column.
package sobel_pkg;
  localparam int PIX_W = 8;
  typedef logic [PIX_W-1:0] pixel_t;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
  localparam int WIN_N  = 9;
endpackage

// File: rtl/window3x3_if.sv
// Pixel-in / window-out handshake bundle for window3x3.
// slave is the window former, master the surrounding pipeline.
interface window3x3_if
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8
) ();
  logic                       valid_i;
  logic                       ready_o;
  logic [WIDTH_P-1:0]         pixel_i;
  logic                       valid_o;
  logic                       ready_i;
  logic [WIN_N*WIDTH_P-1:0]   window_o;
  logic                       last_o;

  modport slave (
    input  valid_i, pixel_i, ready_i,
    output ready_o, valid_o, window_o, last_o
  );

  modport master (
    output valid_i, pixel_i, ready_i,
    input  ready_o, valid_o, window_o, last_o
  );
endinterface

// File: rtl/line_buffer.sv
// One image line of storage: single write port, combinational
// read at the same address. Contents are deliberately not reset.
module line_buffer #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  localparam int AW = $clog2(DEPTH_P)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH_P-1:0] wdata_i,
  output logic [WIDTH_P-1:0] rdata_o
);
  logic [WIDTH_P-1:0] mem [DEPTH_P];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];
endmodule

// File: rtl/window3x3.sv
// Forms 3x3 neighbourhoods from a raster gray stream, emitting one
// window per interior pixel (valid padding) with valid/ready flow.
module window3x3
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640,
  parameter int IMG_H_P = 480
) (
  input  logic        clk_i,
  input  logic        rst_i,
  window3x3_if.slave  bus
);
  localparam int CW = $clog2(IMG_W_P);
  localparam int RW = $clog2(IMG_H_P);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          valid_q;
  logic          last_q;
  logic          acc;
  logic          col_end;
  logic          row_end;
  logic          emit;

  logic [WIDTH_P-1:0] lb0_rd;
  logic [WIDTH_P-1:0] lb1_rd;

  logic [2:0][2:0][WIDTH_P-1:0] win_q;
  logic [2:0][2:0][WIDTH_P-1:0] win_d;

  assign bus.ready_o = !valid_q || bus.ready_i;
  assign acc         = bus.valid_i && bus.ready_o;
  assign col_end     = col_q == CW'(IMG_W_P - 1);
  assign row_end     = row_q == RW'(IMG_H_P - 1);
  assign emit        = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // lb1 inherits lb0's old entry so the pair always holds the two prior lines
  line_buffer #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) lb0 (
    .clk_i   (clk_i),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (bus.pixel_i),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.WIDTH_P(WIDTH_P), .DEPTH_P(IMG_W_P)) lb1 (
    .clk_i   (clk_i),
    .we_i    (acc),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb1_rd;
    win_d[1][2] = lb0_rd;
    win_d[2][2] = bus.pixel_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      win_q   <= '0;
    end else if (acc) begin
      win_q   <= win_d;
      valid_q <= emit;
      last_q  <= emit && col_end && row_end;
      col_q   <= col_end ? '0 : col_q + CW'(1);
      if (col_end) row_q <= row_end ? '0 : row_q + RW'(1);
    end else if (bus.ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.last_o   = last_q;
  assign bus.window_o = win_q;
endmodule

// File: doc/window3x3.md
# window3x3

Forms 3×3 neighbourhoods of grayscale pixels for the Sobel gradient stage. Consumes the raster-order gray stream from the colour-to-gray converter, buffers the two previous image lines, and emits one flattened 3×3 window per interior pixel (valid-padding: no border windows). It sits between grayscale conversion and the Sobel kernel, with valid/ready handshakes on both sides.

## Interface

- `WIDTH_P`, 8, pixel width in bits.
- `IMG_W_P`, 640, pixels per line. Must be ≥ 3.
- `IMG_H_P`, 480, lines per frame. Must be ≥ 3.

Ports:

- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `valid_i`  in  1  upstream pixel valid.
- `ready_o`  out  1  block can accept a pixel.
- `pixel_i`  in  `WIDTH_P`  gray pixel, raster order.
- `valid_o`  out  1  window valid.
- `ready_i`  in  1  downstream accepts the window.
- `window_o`  out  `9*WIDTH_P`  3×3 window.
  - Element k = r*3 + c occupies bits `[k*WIDTH_P +: WIDTH_P]`.
  - r = 0 is the oldest (top) line; c = 0 is the oldest (left) column.
- `last_o`  out  1  window is the final one of the frame.

## Operation

- **Accept rule.**
  - A pixel is accepted on a cycle where `valid_i && ready_o`.
  - `ready_o = !valid_o || ready_i`. This is combinational; it gives one window per cycle under full throughput.
- **Position counters.**
  - `col_q` counts 0..`IMG_W_P`-1 and `row_q` counts 0..`IMG_H_P`-1.
  - Counter widths are `$clog2` of the respective size.
  - Counters advance only on accept.
  - `col_q` wraps to 0 and increments `row_q`.
  - At (`IMG_H_P`-1, `IMG_W_P`-1) both counters wrap to 0; the next pixel starts a new frame.
- **Line buffers.**
  - Two buffers of depth `IMG_W_P`: lb0 holds the previous line, lb1 the line before that.
  - Read is combinational at address `col_q`.
  - On accept: lb1[col_q] ← lb0[col_q], and lb0[col_q] ← `pixel_i`.
- **Window registers.**
  - A 3×3 register array.
  - On accept, each row shifts one column toward c = 0.
  - The new c = 2 column is {r0: lb1[col_q], r1: lb0[col_q], r2: `pixel_i`}.
- **Emission.**
  - An accepted pixel at `row_q` ≥ 2 and `col_q` ≥ 2 sets `valid_o` on the next cycle.
  - The emitted window is the post-shift array.
  - `last_o` is set iff the pixel was at (`IMG_H_P`-1, `IMG_W_P`-1).
  - An accept at any other position, or no accept with `ready_i` high, clears `valid_o`.
- **Window counts.**
  - Windows per frame = (`IMG_W_P`-2)·(`IMG_H_P`-2).
  - Columns c = 0..2 always come from the same line, because emission requires `col_q` ≥ 2. Stale data from the previous line is never exposed.
- **Hold under backpressure.**
  - While `valid_o && !ready_i`, `window_o`, `last_o` and `valid_o` are held.
  - `ready_o` is low, and no accept occurs.

## Timing

- Latency: 1 cycle from accepting the pixel to `valid_o` for its window.
- Throughput: 1 pixel and 1 window per cycle when `ready_i` is held high.
- Reset values:
  - `valid_o` = 0, `last_o` = 0.
  - `window_o` = 0 (window registers cleared).
  - `col_q` = `row_q` = 0.
  - Line buffer contents are not reset; rows 0–1 of every frame overwrite them before use.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Any pending window is dropped. The next accepted pixel is treated as (0,0).
- Simultaneous `ready_i` and accept: the old window is consumed and the new window is registered in the same edge, with no bubble.
- `valid_i` may drop at any time; counters and buffers hold while it is low.

## Structure

- Shared package `sobel_pkg`:
  - `pixel_t` (`logic [WIDTH_P-1:0]`).
  - Window index constants `WIN_TL`..`WIN_BR` (0..8).
  - `WIN_N` = 9.
- One sub-module: `line_buffer`.
  - Parameters `WIDTH_P`, `DEPTH_P`.
  - Single write port plus combinational read at the same address.
  - Instantiated twice: lb0 and lb1.
- Counters, window array and output register live in `window3x3`.

## Test plan

All scenarios use `IMG_W_P` = 4, `IMG_H_P` = 4, `WIDTH_P` = 8, and pixel value = row·16 + col.

- **Streaming, first window.**
  - Stimulus: one frame with `ready_i` = 1 throughout.
  - First window appears the cycle after pixel (2,2).
  - Required: row 0 = 00,01,02; row 1 = 10,11,12; row 2 = 20,21,22.
  - Exactly 4 windows are emitted.
- **Streaming, last window.** The window after (3,3) has centre 22, bottom row 31,32,33, and `last_o` = 1. No other window has `last_o` set.
- **Backpressure.**
  - Stimulus: `ready_i` = 0 for 5 cycles while `valid_o` = 1.
  - Required: `ready_o` = 0, `window_o` stable, no counter advance.
  - After release, the remaining windows arrive in order with correct values.
- **Upstream gaps.**
  - Stimulus: `valid_i` randomly deasserted.
  - Required: the window sequence is identical to the gapless run.
- **Two back-to-back frames.** The second frame's first window equals the first frame's, with no contamination from frame 1's last line.
- **Mid-frame reset.**
  - Stimulus: assert `rst_i` after pixel (2,3), then restart the frame.
  - Required: `valid_o` drops immediately.
  - Required: the restarted frame yields exactly the 4 correct windows.
